// File: rtl/dial_entry_ctrl.sv
// dial_entry_ctrl
//   Edits an 8-bit setting with one rotary dial, one hex digit at a time.
//   A press enters the high digit, a second press moves to the low digit,
//   and a third press commits the edit buffer to the setting. If the dial
//   stays inactive for a long time while editing, the edit is abandoned.
//   The selected digit blinks. All outputs are registered.
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   rot_cw       one-cycle pulse, one clockwise detent
//   rot_ccw      one-cycle pulse, one counter-clockwise detent
//   click_n      raw dial click level, 0 = pressed (asynchronous, bounces)
//   value        committed 8-bit value
//   disp_value   edit buffer while editing, otherwise the committed value
//   digit_blank  [1] blank high digit, [0] blank low digit
//   edit_active  1 while the high or low digit is being edited
//   commit       one-cycle pulse when value is updated
//   abort        one-cycle pulse when an edit is abandoned on inactivity
module dial_entry_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         TIMEOUT_CYCLES  = 500_000_000,
  parameter int         BLINK_CYCLES    = 12_500_000,
  parameter logic [7:0] INIT_VALUE      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_cw,
  input  logic       rot_ccw,
  input  logic       click_n,
  output logic [7:0] value,
  output logic [7:0] disp_value,
  output logic [1:0] digit_blank,
  output logic       edit_active,
  output logic       commit,
  output logic       abort
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EDIT_HI = 2'd1;
  localparam logic [1:0] ST_EDIT_LO = 2'd2;

  logic            click_s1_q, click_s1_d;
  logic            click_s2_q, click_s2_d;
  logic            deb_level_q, deb_level_d;
  logic            deb_prev_q, deb_prev_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [7:0]      buf_q, buf_d;
  logic [7:0]      value_q, value_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [7:0]      disp_value_q, disp_value_d;
  logic [1:0]      digit_blank_q, digit_blank_d;
  logic            edit_active_q, edit_active_d;
  logic            commit_q, commit_d;
  logic            abort_q, abort_d;

  logic press_s;
  logic step_up_s;
  logic step_dn_s;
  logic step_any_s;

  // Wrap a nibble by one detent in either direction; no carry leaves the nibble.
  function automatic logic [3:0] nib_step(input logic [3:0] nib, input logic up, input logic dn);
    logic [3:0] res;
    if (up) begin
      res = nib + 4'd1;
    end else if (dn) begin
      res = nib - 4'd1;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Event decode: press is the debounced falling edge, opposing pulses cancel.
  always_comb begin
    press_s    = deb_prev_q & ~deb_level_q;
    step_up_s  = rot_cw & ~rot_ccw;
    step_dn_s  = rot_ccw & ~rot_cw;
    step_any_s = step_up_s | step_dn_s;
  end

  // Next-state logic for synchroniser, debouncer, FSM, timeout, blink and outputs.
  always_comb begin
    click_s1_d  = click_n;
    click_s2_d  = click_s1_q;
    deb_prev_d  = deb_level_q;
    deb_level_d = deb_level_q;
    deb_cnt_d   = {DB_W{1'b0}};

    // Accept the new level only after it has differed for the full debounce window.
    if (click_s2_q != deb_level_q) begin
      if (deb_cnt_q == DB_LAST) begin
        deb_level_d = click_s2_q;
        deb_cnt_d   = {DB_W{1'b0}};
      end else begin
        deb_cnt_d   = deb_cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
      end
    end else begin
      deb_cnt_d = {DB_W{1'b0}};
    end

    state_d  = state_q;
    buf_d    = buf_q;
    value_d  = value_q;
    to_cnt_d = to_cnt_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;

    // The step is folded into buf_d before the press decision, so a same-cycle
    // step and press commits the stepped value.
    case (state_q)
      ST_IDLE: begin
        to_cnt_d = {TO_W{1'b0}};
        if (press_s) begin
          state_d = ST_EDIT_HI;
          buf_d   = value_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT_HI: begin
        buf_d = {nib_step(buf_q[7:4], step_up_s, step_dn_s), buf_q[3:0]};
        if (press_s) begin
          state_d  = ST_EDIT_LO;
          to_cnt_d = {TO_W{1'b0}};
        end else if (step_any_s) begin
          to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_IDLE;
          abort_d  = 1'b1;
          to_cnt_d = {TO_W{1'b0}};
        end else begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_EDIT_LO: begin
        buf_d = {buf_q[7:4], nib_step(buf_q[3:0], step_up_s, step_dn_s)};
        if (press_s) begin
          state_d  = ST_IDLE;
          value_d  = buf_d;
          commit_d = 1'b1;
          to_cnt_d = {TO_W{1'b0}};
        end else if (step_any_s) begin
          to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_IDLE;
          abort_d  = 1'b1;
          to_cnt_d = {TO_W{1'b0}};
        end else begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d  = ST_IDLE;
        to_cnt_d = {TO_W{1'b0}};
      end
    endcase

    // Blink restarts in the visible phase whenever a new edit state is entered.
    if (state_d == ST_IDLE) begin
      blink_cnt_d = {BL_W{1'b0}};
      phase_d     = 1'b0;
    end else if (state_d != state_q) begin
      blink_cnt_d = {BL_W{1'b0}};
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_cnt_d = {BL_W{1'b0}};
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + {{(BL_W-1){1'b0}}, 1'b1};
      phase_d     = phase_q;
    end

    edit_active_d = (state_d != ST_IDLE);
    disp_value_d  = edit_active_d ? buf_d : value_d;

    case (state_d)
      ST_EDIT_HI: digit_blank_d = {phase_d, 1'b0};
      ST_EDIT_LO: digit_blank_d = {1'b0, phase_d};
      default:    digit_blank_d = 2'b00;
    endcase
  end

  // State registers with synchronous reset; click level resets to released.
  always_ff @(posedge clk) begin
    if (rst) begin
      click_s1_q    <= 1'b1;
      click_s2_q    <= 1'b1;
      deb_level_q   <= 1'b1;
      deb_prev_q    <= 1'b1;
      deb_cnt_q     <= {DB_W{1'b0}};
      state_q       <= ST_IDLE;
      buf_q         <= INIT_VALUE;
      value_q       <= INIT_VALUE;
      to_cnt_q      <= {TO_W{1'b0}};
      blink_cnt_q   <= {BL_W{1'b0}};
      phase_q       <= 1'b0;
      disp_value_q  <= INIT_VALUE;
      digit_blank_q <= 2'b00;
      edit_active_q <= 1'b0;
      commit_q      <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      click_s1_q    <= click_s1_d;
      click_s2_q    <= click_s2_d;
      deb_level_q   <= deb_level_d;
      deb_prev_q    <= deb_prev_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      buf_q         <= buf_d;
      value_q       <= value_d;
      to_cnt_q      <= to_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      disp_value_q  <= disp_value_d;
      digit_blank_q <= digit_blank_d;
      edit_active_q <= edit_active_d;
      commit_q      <= commit_d;
      abort_q       <= abort_d;
    end
  end

  assign value       = value_q;
  assign disp_value  = disp_value_q;
  assign digit_blank = digit_blank_q;
  assign edit_active = edit_active_q;
  assign commit      = commit_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_dial_entry_ctrl.sv
// tb_dial_entry_ctrl
//   Self-checking bench for dial_entry_ctrl with small timing parameters.
//   A transaction-level model tracks edit mode, edit buffer, committed value
//   and expected pulse counts; directed scenarios are followed by random ops.
module tb_dial_entry_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 100;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_cw;
  logic       rot_ccw;
  logic       click_n;
  logic [7:0] value;
  logic [7:0] disp_value;
  logic [1:0] digit_blank;
  logic       edit_active;
  logic       commit;
  logic       abort;

  dial_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .BLINK_CYCLES   (BLK),
    .INIT_VALUE     (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rot_cw     (rot_cw),
    .rot_ccw    (rot_ccw),
    .click_n    (click_n),
    .value      (value),
    .disp_value (disp_value),
    .digit_blank(digit_blank),
    .edit_active(edit_active),
    .commit     (commit),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 = idle, 1 = editing high digit, 2 = editing low digit.
  int         m_mode;
  logic [7:0] m_buf;
  logic [7:0] m_val;
  int         m_commits;
  int         m_aborts;

  // Pulses observed on the DUT outputs.
  int n_commit = 0;
  int n_abort  = 0;
  int n_both   = 0;

  always @(negedge clk) begin
    if (commit) n_commit++;
    if (abort)  n_abort++;
    if (commit && abort) n_both++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_buf  = 8'h00;
    m_val  = 8'h00;
  endtask

  task automatic model_press();
    case (m_mode)
      0: begin m_mode = 1; m_buf = m_val; end
      1: m_mode = 2;
      2: begin m_mode = 0; m_val = m_buf; m_commits++; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic model_step(input logic cw, input logic ccw);
    int d;
    int hi;
    int lo;
    if (m_mode != 0 && cw != ccw) begin
      d  = cw ? 1 : -1;
      hi = int'(m_buf[7:4]);
      lo = int'(m_buf[3:0]);
      if (m_mode == 1) hi = (hi + d + 16) % 16;
      else             lo = (lo + d + 16) % 16;
      m_buf = 8'(hi * 16 + lo);
    end
  endtask

  // Hold the click low for 8 cycles, release, then wait `settle` cycles.
  task automatic do_press(input int settle);
    @(negedge clk);
    click_n = 1'b0;
    repeat (8) @(negedge clk);
    click_n = 1'b1;
    repeat (settle) @(negedge clk);
    model_press();
  endtask

  task automatic do_step(input logic cw, input logic ccw);
    @(negedge clk);
    rot_cw  = cw;
    rot_ccw = ccw;
    @(negedge clk);
    rot_cw  = 1'b0;
    rot_ccw = 1'b0;
    repeat (2) @(negedge clk);
    model_step(cw, ccw);
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_value"}, 32'(value), 32'(m_val));
    check_val({tag, "_edit"}, 32'(edit_active), (m_mode != 0) ? 32'd1 : 32'd0);
    check_val({tag, "_disp"}, 32'(disp_value), (m_mode != 0) ? 32'(m_buf) : 32'(m_val));
    check_val({tag, "_commits"}, 32'(n_commit), 32'(m_commits));
    check_val({tag, "_aborts"}, 32'(n_abort), 32'(m_aborts));
    if (m_mode == 0) check_val({tag, "_blank_idle"}, 32'(digit_blank), 32'd0);
  endtask

  // Wait for the hidden phase of one digit, then measure its length.
  task automatic check_blink(input string tag, input logic [1:0] hid);
    int got;
    int wrong;
    int run;
    got   = 0;
    wrong = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (digit_blank == hid) begin
        got = 1;
        break;
      end else if (digit_blank != 2'b00) begin
        wrong++;
      end
    end
    check_val({tag, "_seen"}, 32'(got), 32'd1);
    run = 0;
    if (got == 1) begin
      run = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (digit_blank == hid) run++;
        else begin
          if (digit_blank != 2'b00) wrong++;
          break;
        end
      end
    end
    check_val({tag, "_run"}, 32'(run), 32'(BLK));
    check_val({tag, "_wrongbit"}, 32'(wrong), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    int found;
    int op;
    int quiet_ops;
    logic [7:0] saved;

    rst       = 1'b1;
    rot_cw    = 1'b0;
    rot_ccw   = 1'b0;
    click_n   = 1'b1;
    m_commits = 0;
    m_aborts  = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. reset state
    check_val("rst_value", 32'(value), 32'h00);
    check_val("rst_disp", 32'(disp_value), 32'h00);
    check_val("rst_edit", 32'(edit_active), 32'd0);
    check_val("rst_commit", 32'(commit), 32'd0);
    check_val("rst_abort", 32'(abort), 32'd0);
    check_val("rst_blank", 32'(digit_blank), 32'd0);

    // 2. press, 3x cw, press, 2x ccw, press -> 3E
    do_press(10);
    check_state("s2_enter");
    repeat (3) do_step(1'b1, 1'b0);
    check_val("s2_hi_disp", 32'(disp_value), 32'h30);
    do_press(10);
    repeat (2) do_step(1'b0, 1'b1);
    check_val("s2_lo_disp", 32'(disp_value), 32'h3E);
    do_press(10);
    check_val("s2_value", 32'(value), 32'h3E);
    check_val("s2_commit_cnt", 32'(n_commit), 32'd1);
    check_state("s2_done");

    // 3. short glitch on click -> no press
    @(negedge clk);
    click_n = 1'b0;
    repeat (2) @(negedge clk);
    click_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("s3_edit", 32'(edit_active), 32'd0);
    check_state("s3");

    // 4. edit, 1x cw, then inactivity -> abort after exactly TMO quiet cycles
    do_press(10);
    @(negedge clk);
    rot_cw = 1'b1;
    @(negedge clk);
    rot_cw = 1'b0;
    model_step(1'b1, 1'b0);
    quiet = 0;
    found = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (abort) begin
        quiet = i;
        found = 1;
        break;
      end
    end
    check_val("s4_abort_seen", 32'(found), 32'd1);
    check_val("s4_abort_delay", 32'(quiet), 32'(TMO));
    m_mode = 0;
    m_aborts++;
    repeat (3) @(negedge clk);
    check_val("s4_value", 32'(value), 32'h3E);
    check_state("s4");

    // 5. from F0: cw on high, ccw on low -> 0F (no carry/borrow)
    do_press(10);
    repeat (2) do_step(1'b1, 1'b0);   // 3 -> 5
    repeat (6) do_step(1'b0, 1'b1);   // 5 -> F
    do_press(10);
    repeat (2) do_step(1'b1, 1'b0);   // E -> 0
    do_press(10);
    check_val("s5_setup", 32'(value), 32'hF0);
    do_press(10);
    do_step(1'b1, 1'b0);
    check_val("s5_hi_wrap", 32'(disp_value), 32'h00);
    do_press(10);
    do_step(1'b0, 1'b1);
    check_val("s5_lo_wrap", 32'(disp_value), 32'h0F);
    do_press(10);
    check_val("s5_value", 32'(value), 32'h0F);
    check_state("s5");

    // 6. cw&ccw together leaves buffer unchanged; reset mid EDIT_LO
    do_press(10);
    saved = disp_value;
    do_step(1'b1, 1'b1);
    check_val("s6_both", 32'(disp_value), 32'(saved));
    do_press(10);
    do_step(1'b1, 1'b0);
    check_state("s6_lo");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("s6_rst_value", 32'(value), 32'h00);
    check_val("s6_rst_edit", 32'(edit_active), 32'd0);
    check_state("s6_rst");

    // Blink: selected digit only, hidden for BLK cycles, restarts per state
    do_press(0);
    check_blink("blink_hi", 2'b10);
    do_press(0);
    check_blink("blink_lo", 2'b01);
    do_press(10);
    check_state("blink_done");

    // Random operations against the model
    quiet_ops = 0;
    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 9));
      if (quiet_ops >= 4) op = 2;
      case (op)
        0, 1:    do_press(10);
        2, 3, 4: do_step(1'b1, 1'b0);
        5, 6, 7: do_step(1'b0, 1'b1);
        8:       do_step(1'b1, 1'b1);
        default: repeat (3) @(negedge clk);
      endcase
      if (op >= 8) quiet_ops++;
      else         quiet_ops = 0;
      check_state("rnd");
    end

    check_val("never_both", 32'(n_both), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
